// File: rtl/load_store_ctrl.sv
// Data-memory load/store sequencer: word-aligned req/gnt/rvalid handshake, byte strobes, load alignment and extension.
// Define LSU_MISALIGN_SPLIT_EN to split misaligned accesses into two word accesses; otherwise they return an error.
module load_store_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              reqValid,
    output logic              reqReady,
    input  logic              reqWrite,
    input  logic [2:0]        reqFunc3,
    input  logic [ADDR_W-1:0] reqAddr,
    input  logic [31:0]       reqWdata,
    output logic              respValid,
    output logic [31:0]       respData,
    output logic              respErr,
    output logic              busy,
    output logic              memReq,
    input  logic              memGnt,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [3:0]        memStrb,
    output logic [31:0]       memWdata,
    input  logic              memRvalid,
    input  logic [31:0]       memRdata
);

    typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE} state_t;

`ifdef LSU_MISALIGN_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    state_t            state;
    logic              write_q;
    logic              split_q;
    logic [2:0]        func3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        mask_hi_q;
    logic [31:0]       wdata_hi_q;
    logic [31:0]       lo_q;

    logic [2:0]        in_size;
    logic [7:0]        in_mask8;
    logic [63:0]       in_shifted;
    logic              in_legal;
    logic              in_misal;
    logic [ADDR_W-1:0] next_addr;
    logic [63:0]       rd_pair;
    logic [31:0]       raw;
    logic [31:0]       load_data;

    // Request decode works on the live inputs because the IDLE decision is made in the acceptance cycle.
    always_comb begin
        case (reqFunc3[1:0])
            2'b01:   in_size = 3'd2;
            2'b10:   in_size = 3'd4;
            default: in_size = 3'd1;
        endcase
        in_mask8   = ((8'd1 << in_size) - 8'd1) << reqAddr[1:0];
        in_shifted = {32'b0, reqWdata} << {reqAddr[1:0], 3'b000};
        in_misal   = |in_mask8[7:4];
        case (reqFunc3)
            3'b000, 3'b001, 3'b010: in_legal = 1'b1;
            3'b100, 3'b101:         in_legal = !reqWrite;
            default:                in_legal = 1'b0;
        endcase
    end

    assign next_addr = {addr_q[ADDR_W-1:2], 2'b00} + ADDR_W'(4);

    // The word returning now is hi in WAIT1 (lo captured earlier) and lo otherwise.
    always_comb begin
        rd_pair = (state == WAIT1) ? {memRdata, lo_q} : {32'b0, memRdata};
        raw     = 32'(rd_pair >> {addr_q[1:0], 3'b000});
        case (func3_q)
            3'b000:  load_data = {{24{raw[7]}}, raw[7:0]};
            3'b001:  load_data = {{16{raw[15]}}, raw[15:0]};
            3'b010:  load_data = raw;
            3'b100:  load_data = {24'b0, raw[7:0]};
            3'b101:  load_data = {16'b0, raw[15:0]};
            default: load_data = '0;
        endcase
    end

    assign reqReady = (state == IDLE);
    assign busy     = (state != IDLE);

    // NOTE: every register here uses non-blocking assignment so all next-state values derive from pre-edge state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            write_q    <= 1'b0;
            split_q    <= 1'b0;
            func3_q    <= '0;
            addr_q     <= '0;
            mask_hi_q  <= '0;
            wdata_hi_q <= '0;
            lo_q       <= '0;
            respValid  <= 1'b0;
            respErr    <= 1'b0;
            respData   <= '0;
            memReq     <= 1'b0;
            memWe      <= 1'b0;
            memAddr    <= '0;
            memStrb    <= '0;
            memWdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (reqValid) begin
                        write_q    <= reqWrite;
                        func3_q    <= reqFunc3;
                        addr_q     <= reqAddr;
                        mask_hi_q  <= in_mask8[7:4];
                        wdata_hi_q <= in_shifted[63:32];
                        split_q    <= in_misal && SPLIT_EN;
                        if (!in_legal || (in_misal && !SPLIT_EN)) begin
                            state     <= DONE;
                            respValid <= 1'b1;
                            respErr   <= 1'b1;
                            respData  <= '0;
                        end else begin
                            state    <= REQ0;
                            memReq   <= 1'b1;
                            memWe    <= reqWrite;
                            memAddr  <= {reqAddr[ADDR_W-1:2], 2'b00};
                            memStrb  <= reqWrite ? in_mask8[3:0] : 4'hF;
                            memWdata <= reqWrite ? in_shifted[31:0] : '0;
                        end
                    end
                end
                REQ0: begin
                    if (memGnt) begin
                        if (!write_q) begin
                            memReq <= 1'b0;
                            state  <= WAIT0;
                        end else if (split_q) begin
                            // Second store half follows immediately; memReq stays high across both.
                            state    <= REQ1;
                            memAddr  <= next_addr;
                            memStrb  <= mask_hi_q;
                            memWdata <= wdata_hi_q;
                        end else begin
                            memReq    <= 1'b0;
                            state     <= DONE;
                            respValid <= 1'b1;
                            respData  <= '0;
                        end
                    end
                end
                WAIT0: begin
                    if (memRvalid) begin
                        lo_q <= memRdata;
                        if (split_q) begin
                            state    <= REQ1;
                            memReq   <= 1'b1;
                            memAddr  <= next_addr;
                            memStrb  <= 4'hF;
                            memWdata <= '0;
                        end else begin
                            state     <= DONE;
                            respValid <= 1'b1;
                            respData  <= load_data;
                        end
                    end
                end
                REQ1: begin
                    if (memGnt) begin
                        memReq <= 1'b0;
                        if (write_q) begin
                            state     <= DONE;
                            respValid <= 1'b1;
                            respData  <= '0;
                        end else begin
                            state <= WAIT1;
                        end
                    end
                end
                WAIT1: begin
                    if (memRvalid) begin
                        state     <= DONE;
                        respValid <= 1'b1;
                        respData  <= load_data;
                    end
                end
                DONE: begin
                    respValid <= 1'b0;
                    respErr   <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_ctrl.sv
// Self-checking bench for load_store_ctrl: directed vector table, reset corner cases, and random traffic
// checked against a byte-level memory model.
module tb_load_store_ctrl;

`ifdef LSU_MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic        clk;
    logic        rstn;
    logic        reqValid;
    logic        reqReady;
    logic        reqWrite;
    logic [2:0]  reqFunc3;
    logic [31:0] reqAddr;
    logic [31:0] reqWdata;
    logic        respValid;
    logic [31:0] respData;
    logic        respErr;
    logic        busy;
    logic        memReq;
    logic        memGnt;
    logic        memWe;
    logic [31:0] memAddr;
    logic [3:0]  memStrb;
    logic [31:0] memWdata;
    logic        memRvalid;
    logic [31:0] memRdata;

    load_store_ctrl #(.ADDR_W(32)) dut (
        .clk(clk), .rstn(rstn),
        .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite), .reqFunc3(reqFunc3),
        .reqAddr(reqAddr), .reqWdata(reqWdata),
        .respValid(respValid), .respData(respData), .respErr(respErr), .busy(busy),
        .memReq(memReq), .memGnt(memGnt), .memWe(memWe), .memAddr(memAddr), .memStrb(memStrb),
        .memWdata(memWdata), .memRvalid(memRvalid), .memRdata(memRdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        bit          we;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } acc_t;

    typedef struct {
        bit          w;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          gd;
        int          rd;
        bit          e_err;
        logic [31:0] e_data;
        int          e_lat;
        int          e_nacc;
        logic [31:0] e_addr0;
        logic [3:0]  e_strb0;
        logic [31:0] e_wdata0;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;

    acc_t        acc_q[$];
    acc_t        exp_q[$];
    logic [31:0] mem_w [logic [31:0]];
    logic [7:0]  ref_b [logic [31:0]];

    int          gnt_delay = 0;
    int          rv_delay = 0;
    int          gnt_cnt = 0;
    int          rv_cnt = 0;
    bit          rd_pending = 1'b0;
    logic [31:0] rd_word;
    bit          have_snap = 1'b0;
    acc_t        snap;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] wa);
        return (wa * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] mem_read(input logic [31:0] wa);
        return mem_w.exists(wa) ? mem_w[wa] : init_word(wa);
    endfunction

    function automatic logic [7:0] ref_get(input logic [31:0] ba);
        logic [31:0] w;
        if (ref_b.exists(ba)) return ref_b[ba];
        w = init_word(ba & ~32'd3);
        return 8'(w >> (8 * (ba % 4)));
    endfunction

    task automatic preload(input logic [31:0] wa, input logic [31:0] v);
        mem_w[wa] = v;
        for (int i = 0; i < 4; i++) ref_b[wa + i] = v[i*8 +: 8];
    endtask

    // Memory responder: grants after gnt_delay stall cycles, returns read data rv_delay cycles after the grant cycle.
    initial begin
        memGnt = 1'b0;
        memRvalid = 1'b0;
        memRdata = '0;
        forever begin
            @(negedge clk);
            memGnt = 1'b0;
            memRvalid = 1'b0;
            if (!rstn) begin
                gnt_cnt = 0;
                rd_pending = 1'b0;
                have_snap = 1'b0;
            end else if (rd_pending) begin
                if (rv_cnt == 0) begin
                    memRvalid = 1'b1;
                    memRdata = rd_word;
                    rd_pending = 1'b0;
                end else begin
                    rv_cnt--;
                end
            end else if (memReq) begin
                if (have_snap) begin
                    check("stall_addr", memAddr, snap.addr);
                    check("stall_strb_we", {memStrb, memWe}, {snap.strb, snap.we});
                    check("stall_wdata", memWdata, snap.wdata);
                end else begin
                    snap.addr = memAddr;
                    snap.we = memWe;
                    snap.strb = memStrb;
                    snap.wdata = memWdata;
                    have_snap = 1'b1;
                end
                if (gnt_cnt >= gnt_delay) begin
                    acc_t a;
                    memGnt = 1'b1;
                    gnt_cnt = 0;
                    have_snap = 1'b0;
                    a.addr = memAddr;
                    a.we = memWe;
                    a.strb = memStrb;
                    a.wdata = memWdata;
                    acc_q.push_back(a);
                    if (memWe) begin
                        logic [31:0] w;
                        w = mem_read(memAddr);
                        for (int l = 0; l < 4; l++)
                            if (memStrb[l]) w[l*8 +: 8] = memWdata[l*8 +: 8];
                        mem_w[memAddr] = w;
                    end else begin
                        rd_pending = 1'b1;
                        rd_word = mem_read(memAddr);
                        rv_cnt = rv_delay;
                    end
                end else begin
                    gnt_cnt++;
                end
            end else begin
                have_snap = 1'b0;
            end
        end
    end

    // Reference model: byte-granular view of the access; fills exp_q and updates the reference memory.
    task automatic model(input bit w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                         input int gd, input int rd,
                         output bit e_err, output logic [31:0] e_data, output int e_lat);
        int size;
        int nw;
        bit legal;
        bit misal;
        logic [31:0] v;
        exp_q.delete();
        legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2) || (!w && (f3 == 3'd4 || f3 == 3'd5));
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        misal = (int'(a % 4) + size) > 4;
        e_err = 1'b0;
        e_data = '0;
        if (!legal || (misal && !SPLIT)) begin
            e_err = 1'b1;
            e_lat = 1;
            return;
        end
        nw = misal ? 2 : 1;
        for (int k = 0; k < nw; k++) begin
            acc_t x;
            x.addr = (a & ~32'd3) + 32'(4 * k);
            x.we = w;
            x.strb = w ? 4'h0 : 4'hF;
            x.wdata = '0;
            if (w) begin
                for (int i = 0; i < size; i++) begin
                    logic [31:0] ba;
                    ba = a + 32'(i);
                    if ((ba & ~32'd3) == x.addr) begin
                        x.strb[ba % 4] = 1'b1;
                        x.wdata[(ba % 4) * 8 +: 8] = wd[i*8 +: 8];
                    end
                end
            end
            exp_q.push_back(x);
        end
        if (w) begin
            for (int i = 0; i < size; i++) ref_b[a + 32'(i)] = wd[i*8 +: 8];
        end else begin
            v = '0;
            for (int i = 0; i < size; i++) v = v + (32'(ref_get(a + 32'(i))) << (8 * i));
            case (f3)
                3'd0: e_data = v[7] ? v - 32'd256 : v;
                3'd1: e_data = v[15] ? v - 32'd65536 : v;
                default: e_data = v;
            endcase
        end
        e_lat = 1 + nw * (1 + gd) + (w ? 0 : nw * (1 + rd));
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!reqReady && n < 80) begin
            @(posedge clk); #1;
            n++;
        end
        check("ready_wait", reqReady, 1);
    endtask

    task automatic run_txn(input bit w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                           input int gd, input int rd,
                           output bit got_err, output logic [31:0] got_data, output int lat);
        gnt_delay = gd;
        rv_delay = rd;
        wait_ready();
        acc_q.delete();
        reqValid = 1'b1;
        reqWrite = w;
        reqFunc3 = f3;
        reqAddr = a;
        reqWdata = wd;
        @(posedge clk); #1;
        reqValid = 1'b0;
        reqWrite = 1'($urandom);
        reqFunc3 = 3'($urandom);
        reqAddr = $urandom;
        reqWdata = $urandom;
        lat = 1;
        while (!respValid && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        got_err = respErr;
        got_data = respData;
        check("busy_at_resp", busy, 1);
        check("ready_in_done", reqReady, 0);
        @(posedge clk); #1;
        check("resp_one_pulse", respValid, 0);
        check("ready_after", reqReady, 1);
    endtask

    task automatic cmp_accs();
        check("acc_count", acc_q.size(), exp_q.size());
        for (int i = 0; i < acc_q.size() && i < exp_q.size(); i++) begin
            logic [31:0] m;
            for (int l = 0; l < 4; l++) m[l*8 +: 8] = {8{exp_q[i].strb[l]}};
            check("acc_addr", acc_q[i].addr, exp_q[i].addr);
            check("acc_we_strb", {acc_q[i].we, acc_q[i].strb}, {exp_q[i].we, exp_q[i].strb});
            if (exp_q[i].we) check("acc_wdata", acc_q[i].wdata & m, exp_q[i].wdata);
        end
    endtask

    vec_t        vt[$];
    vec_t        v;
    bit          g_err;
    bit          m_err;
    logic [31:0] g_data;
    logic [31:0] m_data;
    int          g_lat;
    int          m_lat;
    bit          seen;

    initial begin
        rstn = 1'b0;
        reqValid = 1'b0;
        reqWrite = 1'b0;
        reqFunc3 = '0;
        reqAddr = '0;
        reqWdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_memReq_memWe", {memReq, memWe}, 0);
        check("rst_resp", {respValid, respErr}, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", reqReady, 1);
        check("rst_memAddr", memAddr, 0);
        check("rst_memStrb", memStrb, 0);
        check("rst_memWdata", memWdata, 0);
        check("rst_respData", respData, 0);
        rstn = 1'b1;

        preload(32'h1000, 32'h80AA_BBCC);
        preload(32'h3000, 32'h4433_2211);
        preload(32'h3004, 32'h8877_6655);

        //          w  f3     addr          wdata         gd rd err data           lat nacc addr0         strb0 wdata0
        vt.push_back('{0, 3'd0, 32'h1003, 32'h0,        0, 0, 0, 32'hFFFF_FF80, 3, 1, 32'h1000, 4'hF, 32'h0});
        vt.push_back('{0, 3'd4, 32'h1003, 32'h0,        0, 0, 0, 32'h0000_0080, 3, 1, 32'h1000, 4'hF, 32'h0});
        vt.push_back('{0, 3'd1, 32'h1002, 32'h0,        1, 2, 0, 32'hFFFF_80AA, 6, 1, 32'h1000, 4'hF, 32'h0});
        vt.push_back('{0, 3'd5, 32'h1000, 32'h0,        0, 0, 0, 32'h0000_BBCC, 3, 1, 32'h1000, 4'hF, 32'h0});
        vt.push_back('{0, 3'd2, 32'h1000, 32'h0,        2, 1, 0, 32'h80AA_BBCC, 6, 1, 32'h1000, 4'hF, 32'h0});
        vt.push_back('{1, 3'd1, 32'h2002, 32'h1234_ABCD, 3, 0, 0, 32'h0,        5, 1, 32'h2000, 4'hC, 32'hABCD_0000});
        vt.push_back('{1, 3'd4, 32'h2000, 32'h1111_1111, 0, 0, 1, 32'h0,        1, 0, 32'h0,    4'h0, 32'h0});
        vt.push_back('{1, 3'd5, 32'h2000, 32'h2222_2222, 0, 0, 1, 32'h0,        1, 0, 32'h0,    4'h0, 32'h0});
        vt.push_back('{0, 3'd3, 32'h1000, 32'h0,        0, 0, 1, 32'h0,        1, 0, 32'h0,    4'h0, 32'h0});
        vt.push_back('{0, 3'd7, 32'h1000, 32'h0,        0, 0, 1, 32'h0,        1, 0, 32'h0,    4'h0, 32'h0});
        vt.push_back('{1, 3'd0, 32'h5001, 32'h7777_77EE, 0, 0, 0, 32'h0,        2, 1, 32'h5000, 4'h2, 32'h7777_EE00});
        vt.push_back('{0, 3'd4, 32'h5001, 32'h0,        0, 0, 0, 32'h0000_00EE, 3, 1, 32'h5000, 4'hF, 32'h0});
`ifdef LSU_MISALIGN_SPLIT_EN
        vt.push_back('{0, 3'd2, 32'h3001, 32'h0,        0, 0, 0, 32'h5544_3322, 5, 2, 32'h3000, 4'hF, 32'h0});
        vt.push_back('{1, 3'd2, 32'h4003, 32'hDDCC_BBAA, 0, 0, 0, 32'h0,        3, 2, 32'h4000, 4'h8, 32'hAA00_0000});
`else
        vt.push_back('{0, 3'd2, 32'h3001, 32'h0,        0, 0, 1, 32'h0,        1, 0, 32'h0,    4'h0, 32'h0});
        vt.push_back('{1, 3'd2, 32'h4003, 32'hDDCC_BBAA, 0, 0, 1, 32'h0,        1, 0, 32'h0,    4'h0, 32'h0});
`endif

        foreach (vt[i]) begin
            v = vt[i];
            model(v.w, v.f3, v.addr, v.wdata, v.gd, v.rd, m_err, m_data, m_lat);
            run_txn(v.w, v.f3, v.addr, v.wdata, v.gd, v.rd, g_err, g_data, g_lat);
            check($sformatf("vec%0d_err", i), g_err, v.e_err);
            check($sformatf("vec%0d_data", i), g_data, v.e_data);
            check($sformatf("vec%0d_lat", i), g_lat, v.e_lat);
            check($sformatf("vec%0d_nacc", i), acc_q.size(), v.e_nacc);
            if (v.e_nacc > 0 && acc_q.size() > 0) begin
                check($sformatf("vec%0d_addr0", i), acc_q[0].addr, v.e_addr0);
                check($sformatf("vec%0d_strb0", i), acc_q[0].strb, v.e_strb0);
                if (v.w) check($sformatf("vec%0d_wdata0", i), acc_q[0].wdata, v.e_wdata0);
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            if (v.w && v.addr == 32'h4003 && acc_q.size() > 1) begin
                check("sw_split_addr1", acc_q[1].addr, 32'h4004);
                check("sw_split_strb1", acc_q[1].strb, 4'h7);
                check("sw_split_wdata1", acc_q[1].wdata, 32'h00DD_CCBB);
            end
`endif
        end

        // Reset while waiting for read data: access abandoned, no response.
        gnt_delay = 0;
        rv_delay = 6;
        wait_ready();
        reqValid = 1'b1; reqWrite = 1'b0; reqFunc3 = 3'd2; reqAddr = 32'h1000;
        @(posedge clk); #1;
        reqValid = 1'b0;
        @(posedge clk); #1;
        check("rstw_busy_before", busy, 1);
        rstn = 1'b0;
        #1;
        check("rstw_busy_fall", busy, 0);
        check("rstw_memReq", memReq, 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (respValid) seen = 1'b1;
        end
        check("rstw_no_resp", seen, 0);

        // Reset while a request is stalled on grant: memReq drops at once.
        gnt_delay = 20;
        wait_ready();
        reqValid = 1'b1; reqWrite = 1'b1; reqFunc3 = 3'd2; reqAddr = 32'h1000; reqWdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        reqValid = 1'b0;
        @(posedge clk); #1;
        check("rstq_memReq_before", memReq, 1);
        rstn = 1'b0;
        #1;
        check("rstq_memReq_fall", memReq, 0);
        check("rstq_memAddr", memAddr, 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (respValid || memReq) seen = 1'b1;
        end
        check("rstq_quiet", seen, 0);
        run_txn(1'b0, 3'd0, 32'h1003, 32'h0, 0, 0, g_err, g_data, g_lat);
        check("post_rst_data", g_data, 32'hFFFF_FF80);
        check("post_rst_lat", g_lat, 3);

        // Random traffic in a small window so loads hit earlier stores.
        for (int n = 0; n < 150; n++) begin
            bit          w;
            logic [2:0]  f3;
            logic [31:0] a;
            logic [31:0] wd;
            int          gd;
            int          rd;
            w = 1'($urandom);
            f3 = 3'($urandom);
            a = 32'h8000 + 32'($urandom_range(0, 31));
            wd = $urandom;
            gd = $urandom_range(0, 2);
            rd = $urandom_range(0, 2);
            model(w, f3, a, wd, gd, rd, m_err, m_data, m_lat);
            run_txn(w, f3, a, wd, gd, rd, g_err, g_data, g_lat);
            check("rnd_err", g_err, m_err);
            check("rnd_data", g_data, m_data);
            check("rnd_lat", g_lat, m_lat);
            cmp_accs();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
